phase_monitor: RTL and testbench
================================

PHASE_MONITOR -- requirements
Module: phase_monitor

Interface
REQ-001 Parameter CYCLE_W, default 16, width of completed-cycle counter.
REQ-002 Parameter HOLD_LIMIT, default 255, max consecutive hold samples before timeout.
REQ-003 Cin  input  1  clock; all state updates on rising edge.
REQ-004 Reset  input  1  reset, synchronous, active-high.
REQ-005 C1_In, C2_In, C3_In  input  1 each  phase lines from the three-phase clock generator, sampled on each rising Cin edge.
REQ-006 Err_Clr  input  1  synchronous clear of Err, Err_Code, Err_Count.
REQ-007 Phase  output  2  registered phase index (0=none, 1=C1, 2=C2, 3=C3).
REQ-008 Phase_Valid  output  1  high while tracking a legal sequence (states P1, P2, P3).
REQ-009 Stalled  output  1  high while in HOLD.
REQ-010 Cycle_Done  output  1  one-cycle pulse on each completed C1->C2->C3->C1 rotation.
REQ-011 Cycle_Count  output  CYCLE_W  completed rotations, wraps modulo 2^CYCLE_W.
REQ-012 Err  output  1  sticky error flag.
REQ-013 Err_Code  output  2  code of most recent error (0 none, 1 illegal code, 2 sequence violation, 3 hold timeout).
REQ-014 Err_Count  output  8  error events, saturates at 255.

Function
REQ-015 Input code {C1_In,C2_In,C3_In} SHALL be decoded: 100=PH1, 010=PH2, 001=PH3, 111=HOLD code, 000/011/101/110=illegal.
REQ-016 States SHALL be INIT, P1, P2, P3, HOLD; all outputs registered, reflecting the code sampled at the same edge (one-cycle latency from input change).
REQ-017 INIT: PH1->P1, PH2->P2, PH3->P3, HOLD code->HOLD, all without error; illegal->stay INIT, error code 1.
REQ-018 P1: PH2->P2; HOLD code->HOLD; illegal->INIT, code 1; any other legal code->INIT, code 2.
REQ-019 P2: PH3->P3; HOLD code->HOLD; illegal->INIT, code 1; other legal->INIT, code 2.
REQ-020 P3: PH1->P1 with Cycle_Done pulse and Cycle_Count+1; HOLD code->HOLD; illegal->INIT, code 1; other legal->INIT, code 2.
REQ-021 HOLD: HOLD code->stay, hold counter+1; PH2->P2 (generator resumes at C2 after hold); PH1->P1 (generator reset seen); PH3->INIT, code 2; illegal->INIT, code 1.
REQ-022 Hold counter SHALL clear on entering HOLD and on leaving; when it reaches HOLD_LIMIT while still in HOLD, error code 3 raised once per hold episode, state stays HOLD.
REQ-023 On any error event: Err<=1, Err_Code<=code, Err_Count<=min(Err_Count+1,255).
REQ-024 Err_Clr and an error event in the same cycle: error event wins (Err=1, Err_Count=1, Err_Code=new code).
REQ-025 Cycle_Done SHALL never assert for a rotation interrupted by HOLD between P3 and P1 (HOLD->P2 path does not count).
REQ-026 Phase SHALL be 0 in INIT and HOLD, 1/2/3 in P1/P2/P3.

Reset
REQ-027 While Reset high: state INIT, Phase=0, Phase_Valid=0, Stalled=0, Cycle_Done=0, Cycle_Count=0, Err=0, Err_Code=0, Err_Count=0, hold counter=0.
REQ-028 Reset mid-rotation SHALL discard partial rotation; first sample after release is handled per INIT rules.

Structure
REQ-029 Shared package phase_monitor_pkg SHALL hold state encoding, phase code constants (100/010/001/111) and error code constants.
REQ-030 One sub-module sat_counter (parameterised width, increment, clear, saturate) SHALL implement Err_Count and the hold counter.

Verification
REQ-031 Reset release, feed 100,010,001,100 x4 -> Cycle_Done pulses 3 times on P3->P1 edges, Cycle_Count=3... then 4 after next 100, Err=0.
REQ-032 In P1 feed 001 -> state INIT, Err=1, Err_Code=2, Err_Count=1, Phase_Valid=0 next cycle.
REQ-033 Feed 110 in P2 -> Err_Code=1; then 010 -> P2 without new error, Err_Count unchanged.
REQ-034 P3, then 111 x3, then 010 -> Stalled high 3 cycles, Phase=2, Cycle_Done never asserted, no error.
REQ-035 HOLD_LIMIT=4, hold 10 cycles -> exactly one code-3 error, Err_Count=1, state remains HOLD.
REQ-036 Force 300 illegal samples -> Err_Count=255; Err_Clr with no error -> Err=0, Err_Count=0; Err_Clr with concurrent error -> Err_Count=1.

Source files
------------

// File: rtl/phase_monitor_pkg.sv
// Shared definitions for the three-phase clock monitor: state encoding,
// phase-line codes, error codes and small decode helpers.
package phase_monitor_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_HOLD
  } state_t;

  // Classified meaning of one {C1,C2,C3} sample
  typedef enum logic [2:0] {
    IN_PH1,
    IN_PH2,
    IN_PH3,
    IN_HOLD,
    IN_ILLEGAL
  } in_kind_t;

  localparam logic [2:0] CODE_PH1  = 3'b100;
  localparam logic [2:0] CODE_PH2  = 3'b010;
  localparam logic [2:0] CODE_PH3  = 3'b001;
  localparam logic [2:0] CODE_HOLD = 3'b111;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_SEQ     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  function automatic in_kind_t decode_code(input logic [2:0] code);
    case (code)
      CODE_PH1:  return IN_PH1;
      CODE_PH2:  return IN_PH2;
      CODE_PH3:  return IN_PH3;
      CODE_HOLD: return IN_HOLD;
      default:   return IN_ILLEGAL;
    endcase
  endfunction

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      ST_P1:   return 2'd1;
      ST_P2:   return 2'd2;
      ST_P3:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/phase_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear. A clear coinciding with an
// increment loads 1, so the increment is never lost.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Cin,
  input  logic             Reset,
  input  logic             Clr,
  input  logic             Inc,
  output logic [WIDTH-1:0] Count
);

  // Count register: reset, clear (with optional same-cycle increment), saturate at all-ones
  always_ff @(posedge Cin) begin
    if (Reset) begin
      Count <= '0;
    end else if (Clr) begin
      Count <= Inc ? WIDTH'(1) : '0;
    end else if (Inc && (Count != '1)) begin
      Count <= Count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/phase_monitor.sv
// Tracks the C1->C2->C3 rotation of a three-phase clock generator, counts
// completed rotations, tolerates generator hold periods and records errors.
module phase_monitor
  import phase_monitor_pkg::*;
#(
  parameter int unsigned CYCLE_W    = 16,
  parameter int unsigned HOLD_LIMIT = 255
) (
  input  logic               Cin,
  input  logic               Reset,
  input  logic               C1_In,
  input  logic               C2_In,
  input  logic               C3_In,
  input  logic               Err_Clr,
  output logic [1:0]         Phase,
  output logic               Phase_Valid,
  output logic               Stalled,
  output logic               Cycle_Done,
  output logic [CYCLE_W-1:0] Cycle_Count,
  output logic               Err,
  output logic [1:0]         Err_Code,
  output logic [7:0]         Err_Count
);

  localparam int unsigned         HOLD_W    = $clog2(HOLD_LIMIT + 1);
  // Counter value on the stay-in-hold sample that takes it to HOLD_LIMIT.
  // The counter saturates above HOLD_LIMIT, so this matches at most once per episode.
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_LIMIT - 1);

  state_t            state, nxt;
  in_kind_t          kind;
  logic              err_ev;
  logic [1:0]        err_cd;
  logic              rot_done;
  logic              hold_clr, hold_inc;
  logic [HOLD_W-1:0] hold_cnt;

  // Next-state decode and error classification for the current sample
  always_comb begin
    kind     = decode_code({C1_In, C2_In, C3_In});
    nxt      = state;
    err_ev   = 1'b0;
    err_cd   = ERR_NONE;
    rot_done = 1'b0;
    case (state)
      ST_INIT: begin
        case (kind)
          IN_PH1:  nxt = ST_P1;
          IN_PH2:  nxt = ST_P2;
          IN_PH3:  nxt = ST_P3;
          IN_HOLD: nxt = ST_HOLD;
          default: begin
            err_ev = 1'b1;
            err_cd = ERR_ILLEGAL;
          end
        endcase
      end
      ST_P1, ST_P2, ST_P3: begin
        if (kind == IN_HOLD) begin
          nxt = ST_HOLD;
        end else if (kind == IN_ILLEGAL) begin
          nxt    = ST_INIT;
          err_ev = 1'b1;
          err_cd = ERR_ILLEGAL;
        end else if (state == ST_P1 && kind == IN_PH2) begin
          nxt = ST_P2;
        end else if (state == ST_P2 && kind == IN_PH3) begin
          nxt = ST_P3;
        end else if (state == ST_P3 && kind == IN_PH1) begin
          nxt      = ST_P1;
          rot_done = 1'b1;
        end else begin
          nxt    = ST_INIT;
          err_ev = 1'b1;
          err_cd = ERR_SEQ;
        end
      end
      ST_HOLD: begin
        case (kind)
          IN_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              err_ev = 1'b1;
              err_cd = ERR_TIMEOUT;
            end
          end
          IN_PH1: nxt = ST_P1;
          IN_PH2: nxt = ST_P2;
          IN_PH3: begin
            nxt    = ST_INIT;
            err_ev = 1'b1;
            err_cd = ERR_SEQ;
          end
          default: begin
            nxt    = ST_INIT;
            err_ev = 1'b1;
            err_cd = ERR_ILLEGAL;
          end
        endcase
      end
      default: nxt = ST_INIT;
    endcase
    hold_inc = (state == ST_HOLD) && (nxt == ST_HOLD);
    hold_clr = (state == ST_HOLD) != (nxt == ST_HOLD);
  end

  // State and registered status/error outputs; an error beats a same-cycle clear
  always_ff @(posedge Cin) begin
    if (Reset) begin
      state       <= ST_INIT;
      Phase       <= 2'd0;
      Phase_Valid <= 1'b0;
      Stalled     <= 1'b0;
      Cycle_Done  <= 1'b0;
      Cycle_Count <= '0;
      Err         <= 1'b0;
      Err_Code    <= ERR_NONE;
    end else begin
      state       <= nxt;
      Phase       <= phase_of(nxt);
      Phase_Valid <= (nxt == ST_P1) || (nxt == ST_P2) || (nxt == ST_P3);
      Stalled     <= (nxt == ST_HOLD);
      Cycle_Done  <= rot_done;
      if (rot_done) begin
        Cycle_Count <= Cycle_Count + CYCLE_W'(1);
      end
      if (err_ev) begin
        Err      <= 1'b1;
        Err_Code <= err_cd;
      end else if (Err_Clr) begin
        Err      <= 1'b0;
        Err_Code <= ERR_NONE;
      end
    end
  end

  sat_counter #(.WIDTH(8)) u_err_cnt (
    .Cin   (Cin),
    .Reset (Reset),
    .Clr   (Err_Clr),
    .Inc   (err_ev),
    .Count (Err_Count)
  );

  sat_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
    .Cin   (Cin),
    .Reset (Reset),
    .Clr   (hold_clr),
    .Inc   (hold_inc),
    .Count (hold_cnt)
  );

endmodule

// File: tb/tb_phase_monitor.sv
// Scoreboard bench for phase_monitor: a behavioural model predicts every
// registered output per sample; predictions are queued and compared after the edge.
module tb_phase_monitor;

  localparam int unsigned CW = 4;
  localparam int unsigned HL = 4;

  localparam int M_INIT = 0;
  localparam int M_P1   = 1;
  localparam int M_P2   = 2;
  localparam int M_P3   = 3;
  localparam int M_HOLD = 4;

  logic          Cin = 1'b0;
  logic          Reset = 1'b1;
  logic          C1_In = 1'b0, C2_In = 1'b0, C3_In = 1'b0;
  logic          Err_Clr = 1'b0;
  logic [1:0]    Phase;
  logic          Phase_Valid, Stalled, Cycle_Done, Err;
  logic [CW-1:0] Cycle_Count;
  logic [1:0]    Err_Code;
  logic [7:0]    Err_Count;

  phase_monitor #(.CYCLE_W(CW), .HOLD_LIMIT(HL)) dut (
    .Cin         (Cin),
    .Reset       (Reset),
    .C1_In       (C1_In),
    .C2_In       (C2_In),
    .C3_In       (C3_In),
    .Err_Clr     (Err_Clr),
    .Phase       (Phase),
    .Phase_Valid (Phase_Valid),
    .Stalled     (Stalled),
    .Cycle_Done  (Cycle_Done),
    .Cycle_Count (Cycle_Count),
    .Err         (Err),
    .Err_Code    (Err_Code),
    .Err_Count   (Err_Count)
  );

  always #5 Cin = ~Cin;

  typedef struct packed {
    logic [1:0]    phase;
    logic          valid;
    logic          stalled;
    logic          done;
    logic [CW-1:0] cc;
    logic          err;
    logic [1:0]    code;
    logic [7:0]    cnt;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  string scen = "none";

  int    m_st = M_INIT, m_hold = 0, m_cc = 0, m_cnt = 0, m_code = 0;
  logic  m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s got=%0d exp=%0d at %0t", scen, tag, got, exp, $time);
    end
  endtask

  // Predict outputs after one sample and push them to the scoreboard
  task automatic model(input logic [2:0] c, input logic clr, input logic rst);
    int   ph, ec;
    logic cd;
    exp_t e;
    ph = (c == 3'b100) ? 1 : (c == 3'b010) ? 2 : (c == 3'b001) ? 3 : (c == 3'b111) ? 4 : 0;
    ec = 0;
    cd = 1'b0;
    if (rst) begin
      m_st = M_INIT; m_hold = 0; m_cc = 0; m_cnt = 0; m_code = 0; m_err = 1'b0;
    end else begin
      if (m_st == M_INIT) begin
        if (ph == 0) ec = 1;
        else begin
          m_st = ph;
          m_hold = (ph == 4) ? 1 : 0;
        end
      end else if (m_st == M_HOLD) begin
        case (ph)
          4: begin
            m_hold++;
            if (m_hold == HL + 1) ec = 3;
          end
          1, 2: m_st = ph;
          3: begin m_st = M_INIT; ec = 2; end
          default: begin m_st = M_INIT; ec = 1; end
        endcase
      end else begin
        if (ph == 4) begin
          m_st = M_HOLD; m_hold = 1;
        end else if (ph == 0) begin
          m_st = M_INIT; ec = 1;
        end else if (ph == (m_st % 3) + 1) begin
          cd = (m_st == M_P3);
          m_st = ph;
        end else begin
          m_st = M_INIT; ec = 2;
        end
      end
      if (cd) m_cc = (m_cc + 1) % (1 << CW);
      if (ec != 0) begin
        m_err = 1'b1;
        m_code = ec;
        m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else if (clr) begin
        m_err = 1'b0; m_code = 0; m_cnt = 0;
      end
    end
    e.phase   = (m_st >= 1 && m_st <= 3) ? 2'(m_st) : 2'd0;
    e.valid   = (m_st >= 1 && m_st <= 3);
    e.stalled = (m_st == M_HOLD);
    e.done    = cd;
    e.cc      = CW'(m_cc);
    e.err     = m_err;
    e.code    = 2'(m_code);
    e.cnt     = 8'(m_cnt);
    sb.push_back(e);
  endtask

  // Drive one sample, predict, then compare after the sampling edge
  task automatic step(input logic [2:0] c, input logic clr, input logic rst);
    exp_t e;
    @(negedge Cin);
    {C1_In, C2_In, C3_In} = c;
    Err_Clr = clr;
    Reset = rst;
    model(c, clr, rst);
    @(posedge Cin);
    #1;
    e = sb.pop_front();
    check("phase",   32'(Phase),       32'(e.phase));
    check("valid",   32'(Phase_Valid), 32'(e.valid));
    check("stalled", 32'(Stalled),     32'(e.stalled));
    check("done",    32'(Cycle_Done),  32'(e.done));
    check("ccount",  32'(Cycle_Count), 32'(e.cc));
    check("err",     32'(Err),         32'(e.err));
    check("code",    32'(Err_Code),    32'(e.code));
    check("ecount",  32'(Err_Count),   32'(e.cnt));
  endtask

  task automatic s(input logic [2:0] c);
    step(c, 1'b0, 1'b0);
  endtask

  logic [2:0] nc;

  initial begin
    scen = "reset";
    step(3'b100, 1'b0, 1'b1);
    step(3'b010, 1'b0, 1'b1);

    scen = "rotate";
    s(3'b100);
    for (int i = 0; i < 4; i++) begin
      s(3'b010); s(3'b001); s(3'b100);
    end

    scen = "seq_err";
    s(3'b001);
    s(3'b100);

    scen = "illegal_p2";
    s(3'b010); s(3'b110); s(3'b010);

    scen = "hold_resume";
    s(3'b001);
    for (int i = 0; i < 3; i++) s(3'b111);
    s(3'b010); s(3'b001);

    scen = "hold_p1_p3";
    s(3'b111); s(3'b100); s(3'b111); s(3'b001);

    scen = "hold_timeout";
    for (int i = 0; i < 10; i++) s(3'b111);
    s(3'b100);

    scen = "saturate";
    for (int i = 0; i < 300; i++) s(3'b000);
    step(3'b100, 1'b1, 1'b0);
    s(3'b010);
    step(3'b000, 1'b1, 1'b0);

    scen = "reset_mid";
    s(3'b100); s(3'b010);
    step(3'b001, 1'b0, 1'b1);
    s(3'b001); s(3'b100);

    scen = "wrap";
    for (int i = 0; i < 20; i++) begin
      s(3'b010); s(3'b001); s(3'b100);
    end

    scen = "random";
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(99) < 70) begin
        nc = (m_st == M_P1) ? 3'b010 : (m_st == M_P2) ? 3'b001 : 3'b100;
        if ($urandom_range(9) == 0) nc = 3'b111;
      end else begin
        nc = 3'($urandom_range(7));
      end
      step(nc, ($urandom_range(19) == 0), ($urandom_range(99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
